pc_fetch_unit: RTL
==================

# pc_fetch_unit

Parametrised program-counter and instruction-fetch front end for the pipelined RISC-V core, replacing the bare PC register. Holds the fetch PC, issues one outstanding request at a time on a req/gnt/rvalid instruction-bus port toward the AXI master wrapper, and buffers the returned word for IF/ID. Handles load-use hold, global stall and branch/jump/trap redirects, including killing an in-flight fetch.

## Interface
Parameters:
- ADDR_W, 32, PC and bus address width
- RESET_PC, ADDR_W'h0, PC value after reset
- INST_BYTES, 4, PC increment per fetch

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  global stall (memory/bus); freezes PC and buffer consume
- PC_write  in  1  hazard-unit enable; 0 = hold (load-use)
- redirect  in  1  branch/jump/trap taken, single-cycle pulse
- redirect_pc  in  ADDR_W  redirect target
- im_req  out  1  fetch request
- IM_address  out  ADDR_W  fetch address
- im_gnt  in  1  request accepted
- im_rvalid  in  1  read data valid
- im_rdata  in  32  instruction word
- inst_valid  out  1  buffered instruction valid to IF/ID
- inst  out  32  buffered instruction
- PC_out  out  ADDR_W  PC of `inst`

## Operation
- Reset (synchronous, active-high): pc=RESET_PC, state=IDLE, im_req=0, IM_address=RESET_PC, inst_valid=0, inst=0, PC_out=0, pending redirect cleared.
- consume = inst_valid & PC_write & !stall; clears inst_valid next edge unless refilled.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE: if (!inst_valid | consume) and !stall -> REQ.
- REQ: im_req=1, IM_address=pc. Both are held stable until im_gnt. On gnt: pc<=pc+INST_BYTES (mod 2^ADDR_W, wraps), go to WAIT. If a pending redirect was latched, go to DROP with pc<=pend_pc instead.
- WAIT: on im_rvalid: inst<=im_rdata, PC_out<=pc-INST_BYTES (address of the granted request), inst_valid<=1, go to IDLE.
- DROP: on im_rvalid, discard the data and go to IDLE.
- Redirect has priority over stall, PC_write and the buffer. It always clears inst_valid.
  - IDLE: pc<=redirect_pc.
  - REQ without gnt: latch pend_pc=redirect_pc.
  - REQ with gnt: go to DROP, pc<=redirect_pc.
  - WAIT: go to DROP, pc<=redirect_pc. If im_rvalid arrives in the same cycle, the data is dropped and the FSM goes to IDLE.
  - DROP: pc<=redirect_pc, state unchanged.
- Latest redirect wins; pend_pc is overwritten.
- im_gnt/im_rvalid outside REQ/WAIT/DROP are ignored.
- stall does not block bus tracking: gnt and rvalid are always accepted. The buffer loads during stall only if it is empty.
  - A response in WAIT with a full, unconsumed buffer is a protocol impossibility, because IDLE only issues when the buffer frees.

## Timing
- Minimum fetch latency: IDLE→REQ one edge. With gnt in the REQ cycle and rvalid the next cycle, inst_valid rises the cycle after rvalid. That is 3 cycles from leaving IDLE, and the steady-state issue interval is 3 cycles.
- A consume in the inst_valid cycle allows REQ on the next edge.
- Redirect to first valid instruction at redirect_pc: at least 4 cycles from IDLE/WAIT, plus drain time in DROP.
- PC_out/inst stay stable while inst_valid=1 and not consumed.
- Reset mid-transaction: returns to IDLE immediately. The bus side is reset by the same rst, so no stale response is expected. Any stray response that does arrive is ignored.

## Structure
- pc_fetch_pkg: fetch_state_e {IDLE, REQ, WAIT, DROP}, INST_BYTES default, ZeroWord constant. Shared with the IF/ID stage and the AXI wrapper.
- One sub-module: fetch_inst_buf. It is the one-entry instruction/PC holding register with load/consume/flush; the FSM, pc and pending-redirect logic stay in the top.

## Test plan
- Reset, then gnt same cycle and rvalid+1 with rdata=0x00000013 -> inst_valid high 3 cycles after leaving IDLE, PC_out=0x0, next IM_address=0x4.
- PC_write=0 for 5 cycles with inst_valid=1 -> inst/PC_out held, no new im_req. Release -> next request issued one cycle later.
- redirect with redirect_pc=0x100 in WAIT; rvalid arrives 2 cycles later -> data discarded, next im_req with IM_address=0x100.
- redirect with redirect_pc=0x200 during REQ while gnt is withheld 3 cycles -> IM_address stays at the old pc until gnt, the response is dropped, next request goes to 0x200.
- redirect and rvalid in the same WAIT cycle -> inst_valid stays 0 and the FSM goes to IDLE with pc=target. Also check that pc at 0xFFFFFFFC wraps to 0x0 after gnt.
- stall asserted with gnt and rvalid arriving -> both accepted, buffer fills, no consume until stall drops. Reset mid-WAIT -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared definitions for the instruction-fetch front end. These are also
//   used by the IF/ID stage and the AXI master wrapper.
//   - fetch_state_e      : fetch FSM encoding (IDLE, REQ, WAIT, DROP)
//   - DEFAULT_INST_BYTES : default PC increment per fetch
//   - ZeroWord           : all-zero instruction word (reset value of the buffer)
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int DEFAULT_INST_BYTES = 4;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_inst_buf.sv
// fetch_inst_buf
//   One-entry holding register for a fetched instruction and its PC.
//   Priority on each edge: rst, then flush, then load, then consume.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     load            : capture load_inst/load_pc and mark the entry valid
//     load_inst       : instruction word to capture
//     load_pc         : PC of that instruction
//     consume         : downstream took the entry; clear valid
//     flush           : drop the entry (redirect); clear valid
//     inst_valid      : entry holds a live instruction
//     inst, pc_out    : held instruction and its PC (stable while valid)
module fetch_inst_buf
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [31:0]       load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              consume,
    input  logic              flush,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= ZeroWord;
            pc_out     <= '0;
        end else if (flush) begin
            // Only the valid flag is dropped; the data is left as-is.
            inst_valid <= 1'b0;
        end else if (load) begin
            inst_valid <= 1'b1;
            inst       <= load_inst;
            pc_out     <= load_pc;
        end else if (consume) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter and instruction-fetch front end. It keeps at most one
//   request outstanding on a req/gnt/rvalid bus and buffers the returned word
//   for IF/ID. Branch/jump/trap redirects can kill an in-flight fetch.
//
//   Bus handshake: im_req/IM_address are asserted in REQ and held unchanged
//   until the cycle in which im_gnt is high. That cycle is the transfer. After
//   a grant exactly one im_rvalid is expected, carrying im_rdata. im_gnt and
//   im_rvalid seen outside REQ/WAIT/DROP are ignored.
//
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     stall            : global stall; blocks new issue and buffer consume
//     PC_write         : hazard enable (0 = hold for load-use)
//     redirect         : single-cycle taken branch/jump/trap
//     redirect_pc      : redirect target
//     im_req           : fetch request
//     IM_address       : fetch address (current pc)
//     im_gnt           : request accepted
//     im_rvalid        : read data valid
//     im_rdata         : instruction word
//     inst_valid       : buffered instruction valid to IF/ID
//     inst             : buffered instruction
//     PC_out           : PC of inst
//     fsm_state        : current fetch FSM state (fetch_state_e encoding)
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = DEFAULT_INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              PC_write,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              im_req,
    output logic [ADDR_W-1:0] IM_address,
    input  logic              im_gnt,
    input  logic              im_rvalid,
    input  logic [31:0]       im_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] PC_out,
    output logic [1:0]        fsm_state
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] pend_pc, pend_pc_next;
    logic              pend_valid, pend_valid_next;
    logic              consume;
    logic              buf_load;

    assign consume    = inst_valid & PC_write & ~stall;
    assign IM_address = pc;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            pend_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend_pc    <= pend_pc_next;
            pend_valid <= pend_valid_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_pc_next    = pend_pc;
        pend_valid_next = pend_valid;
        im_req          = 1'b0;
        buf_load        = 1'b0;

        unique case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                end else if ((~inst_valid | consume) & ~stall) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                // The request stays up even when a redirect arrives. The
                // address must not change before the grant, so a redirect is
                // parked in pend_pc and applied when the grant comes.
                im_req = 1'b1;
                if (im_gnt) begin
                    pend_valid_next = 1'b0;
                    if (redirect) begin
                        state_next = DROP;
                        pc_next    = redirect_pc;
                    end else if (pend_valid) begin
                        state_next = DROP;
                        pc_next    = pend_pc;
                    end else begin
                        state_next = WAIT;
                        pc_next    = pc + PC_INC;
                    end
                end else if (redirect) begin
                    pend_valid_next = 1'b1;
                    pend_pc_next    = redirect_pc;
                end
            end

            WAIT: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = im_rvalid ? IDLE : DROP;
                end else if (im_rvalid) begin
                    // The buffer is always free here. IDLE only issues once
                    // it has drained, so the load happens even under stall.
                    buf_load   = 1'b1;
                    state_next = IDLE;
                end
            end

            DROP: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                end
                if (im_rvalid) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // pc has already advanced past the granted request, so the PC of the
    // returned word is one increment back (mod 2^ADDR_W).
    fetch_inst_buf #(
        .ADDR_W (ADDR_W)
    ) u_inst_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_inst  (im_rdata),
        .load_pc    (pc - PC_INC),
        .consume    (consume),
        .flush      (redirect),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc_out     (PC_out)
    );

endmodule
